hazard_tracker: RTL

- Write-side counterpart to the decode-stage read decoder of the 5-stage MIPS core (P5).
- The read decoder states which registers an instruction reads (rs/rt, branch/jump type). This block decodes which register each instruction writes and when the value is ready (Tnew), and tracks that through E/M/W.
- It compares that against the D-stage read requirements (Tuse) and produces the stall signal and all forwarding selects.

---
 rtl/hazard_tracker.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/hazard_tracker.sv
// Write-side hazard tracker for the 5-stage MIPS core: tracks destination/Tnew through E/M/W,
// compares against D-stage Tuse, and produces stall and forwarding selects. Stall counter: HAZ_STATS_EN.
module hazard_tracker #(
   parameter int NREG_BITS = 5,
   parameter int TNEW_BITS = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          instr_d,
   input  logic [NREG_BITS-1:0] rs_d,
   input  logic [NREG_BITS-1:0] rt_d,
   input  logic                 j_type,
   input  logic                 b_type,
   output logic                 stall,
   output logic [1:0]           fwd_rs_d,
   output logic [1:0]           fwd_rt_d,
   output logic [1:0]           fwd_rs_e,
   output logic [1:0]           fwd_rt_e,
   output logic                 fwd_rt_m,
   output logic [31:0]          stall_count
);

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_LUI     = 6'b001111;
   localparam logic [5:0] OP_LW      = 6'b100011;
   localparam logic [5:0] OP_SW      = 6'b101011;
   localparam logic [5:0] FN_ADDU    = 6'b100001;
   localparam logic [5:0] FN_SUBU    = 6'b100011;

   localparam logic [NREG_BITS-1:0] REG_ZERO = '0;
   localparam logic [NREG_BITS-1:0] REG_RA   = NREG_BITS'(31);
   localparam logic [TNEW_BITS-1:0] T0       = '0;
   localparam logic [TNEW_BITS-1:0] T1       = TNEW_BITS'(1);
   localparam logic [TNEW_BITS-1:0] T2       = TNEW_BITS'(2);

   // Forwarding select codes.
   localparam logic [1:0] FD_RF = 2'd0;
   localparam logic [1:0] FD_E  = 2'd1;
   localparam logic [1:0] FD_M  = 2'd2;
   localparam logic [1:0] FD_W  = 2'd3;
   localparam logic [1:0] FE_LATCHED = 2'd0;
   localparam logic [1:0] FE_M       = 2'd1;
   localparam logic [1:0] FE_W       = 2'd2;

   typedef struct packed {
      logic [NREG_BITS-1:0] dest;
      logic [TNEW_BITS-1:0] tnew;
      logic [NREG_BITS-1:0] rs;
      logic [NREG_BITS-1:0] rt;
   } stage_t;

   stage_t e_q, e_d;
   stage_t m_q, m_d;
   stage_t w_q, w_d;

   stage_t               dec;
   logic [TNEW_BITS-1:0] tuse_rs;
   logic [TNEW_BITS-1:0] tuse_rt;

   logic [5:0] op;
   logic [5:0] funct;

   assign op    = instr_d[31:26];
   assign funct = instr_d[5:0];

   // rs and shamt fields are supplied by the read decoder / not needed here.
   logic unused_instr_bits;
   assign unused_instr_bits = ^{instr_d[25:21], instr_d[10:6]};

   // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
   always_comb begin
      dec      = '0;
      dec.rs   = rs_d;
      dec.rt   = rt_d;
      case (op)
         OP_SPECIAL: begin
            if (funct == FN_ADDU || funct == FN_SUBU) begin
               dec.dest = instr_d[15:11];
               dec.tnew = T1;
            end
         end
         OP_ORI, OP_LUI: begin
            dec.dest = instr_d[20:16];
            dec.tnew = T1;
         end
         OP_LW: begin
            dec.dest = instr_d[20:16];
            dec.tnew = T2;
         end
         OP_JAL: begin
            dec.dest = REG_RA;
            dec.tnew = T0;
         end
         default: begin
            dec.dest = REG_ZERO;
            dec.tnew = T0;
         end
      endcase
   end

   always_comb begin
      tuse_rs = (b_type || j_type) ? T0 : T1;
      if (b_type) begin
         tuse_rt = T0;
      end else if (op == OP_SW) begin
         tuse_rt = T2;
      end else begin
         tuse_rt = T1;
      end
   end

   // A producer blocks a reader only while its value will not be ready by the reader's Tuse.
   function automatic logic hazard(input logic [NREG_BITS-1:0] src,
                                   input logic [TNEW_BITS-1:0] tuse,
                                   input stage_t               e,
                                   input stage_t               m);
      logic hit_e;
      logic hit_m;
      hit_e = (src == e.dest) && (e.tnew > tuse);
      hit_m = (src == m.dest) && (m.tnew > tuse);
      return (src != REG_ZERO) && (hit_e || hit_m);
   endfunction

   function automatic logic eligible(input logic [NREG_BITS-1:0] src, input stage_t s);
      return (s.dest != REG_ZERO) && (s.dest == src) && (s.tnew == T0);
   endfunction

   function automatic logic [1:0] sel_d(input logic [NREG_BITS-1:0] src,
                                        input stage_t e, input stage_t m, input stage_t w);
      logic [1:0] sel;
      sel = FD_RF;
      if (eligible(src, e)) begin
         sel = FD_E;
      end else if (eligible(src, m)) begin
         sel = FD_M;
      end else if (eligible(src, w)) begin
         sel = FD_W;
      end
      return sel;
   endfunction

   function automatic logic [1:0] sel_e(input logic [NREG_BITS-1:0] src,
                                        input stage_t m, input stage_t w);
      logic [1:0] sel;
      sel = FE_LATCHED;
      if (eligible(src, m)) begin
         sel = FE_M;
      end else if (eligible(src, w)) begin
         sel = FE_W;
      end
      return sel;
   endfunction

   always_comb begin
      stall    = hazard(rs_d, tuse_rs, e_q, m_q) || hazard(rt_d, tuse_rt, e_q, m_q);
      fwd_rs_d = sel_d(rs_d, e_q, m_q, w_q);
      fwd_rt_d = sel_d(rt_d, e_q, m_q, w_q);
      fwd_rs_e = sel_e(e_q.rs, m_q, w_q);
      fwd_rt_e = sel_e(e_q.rt, m_q, w_q);
      fwd_rt_m = (m_q.rt != REG_ZERO) && (m_q.rt == w_q.dest);
   end

   // E/M/W always advance; only D holds, so a stall turns into a bubble in E.
   always_comb begin
      e_d      = stall ? '0 : dec;
      m_d      = e_q;
      m_d.tnew = (e_q.tnew == T0) ? T0 : e_q.tnew - T1;
      w_d      = m_q;
      w_d.tnew = T0;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_q <= '0;
         m_q <= '0;
         w_q <= '0;
      end else begin
         e_q <= e_d;
         m_q <= m_d;
         w_q <= w_d;
      end
   end

`ifdef HAZ_STATS_EN
   logic [31:0] stall_count_q;
   logic [31:0] stall_count_d;

   always_comb begin
      stall_count_d = stall ? stall_count_q + 32'd1 : stall_count_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_count = stall_count_q;
`else
   assign stall_count = '0;
`endif

endmodule
